// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary hex-entry controller: FSM state codes,
// nibble width and helpers that read/write one nibble of a data word.
package rotary_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EDIT    = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;
    localparam logic [1:0] ILLEGAL = 2'd3;

    localparam int NIBBLE_W   = 4;
    // Helpers work on a 64-bit container; callers size-cast in and out.
    localparam int MAX_DATA_W = 64;

    function automatic logic [NIBBLE_W-1:0] get_nibble(
        input logic [MAX_DATA_W-1:0] word,
        input int unsigned           idx
    );
        return NIBBLE_W'(word >> (idx * NIBBLE_W));
    endfunction

    function automatic logic [MAX_DATA_W-1:0] put_nibble(
        input logic [MAX_DATA_W-1:0] word,
        input int unsigned           idx,
        input logic [NIBBLE_W-1:0]   nib
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = MAX_DATA_W'(4'hF) << (idx * NIBBLE_W);
        return (word & ~mask) | (MAX_DATA_W'(nib) << (idx * NIBBLE_W));
    endfunction

endpackage

// File: rtl/rotary_entry_ctrl_edge_pulse.sv
// Rising-edge detector for one encoder input level. History resets to 1 so a
// level that is already high when reset releases never produces an event.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_d;

    // Register the previous level (reset high to suppress a spurious edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_d <= 1'b1;
        else       level_d <= level;
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/rotary_entry_ctrl.sv
// Hex data entry from a rotary encoder. Turns edit the nibble under the cursor,
// presses walk the cursor from MS to LS nibble and then commit the word to
// the front-panel loader. An idle EDIT session times out and restores the
// value it started from.
//
// Output handshake: out_data is a valid word whenever out_valid is high and
// is held stable until the cycle in which out_valid & out_ready are both 1;
// that cycle is the single transfer, after which out_valid drops. out_ready
// is ignored while out_valid is low.
module rotary_entry_ctrl
    import rotary_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26,
    localparam int NIBBLES       = DATA_W / 4,
    localparam int CUR_W         = $clog2(NIBBLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              right,
    input  logic              left,
    input  logic              down,
    output logic [DATA_W-1:0] value,
    output logic [CUR_W-1:0]  cursor,
    output logic              editing,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              aborted,
    output logic [1:0]        dbg_state
);

    localparam logic [CUR_W-1:0] CUR_TOP  = CUR_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic ev_right, ev_left, ev_down;

    edge_pulse u_edge_right (.clk(clk), .reset(reset), .level(right), .pulse(ev_right));
    edge_pulse u_edge_left  (.clk(clk), .reset(reset), .level(left),  .pulse(ev_left));
    edge_pulse u_edge_down  (.clk(clk), .reset(reset), .level(down),  .pulse(ev_down));

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   snapshot;
    logic                turn_up, turn_dn, timed_out, accept;
    logic [NIBBLE_W-1:0] cur_nib;
    logic [DATA_W-1:0]   value_inc, value_dec;

    // Decode events and precompute the edited value for either turn direction.
    always_comb begin
        turn_up   = ev_right & ~ev_left;
        turn_dn   = ev_left & ~ev_right;
        cur_nib   = get_nibble(MAX_DATA_W'(value), 32'(cursor));
        value_inc = DATA_W'(put_nibble(MAX_DATA_W'(value), 32'(cursor), cur_nib + NIBBLE_W'(1)));
        value_dec = DATA_W'(put_nibble(MAX_DATA_W'(value), 32'(cursor), cur_nib - NIBBLE_W'(1)));
        timed_out = (state == EDIT) & ~ev_down & ~turn_up & ~turn_dn & (count == CNT_LAST);
        accept    = (state == COMMIT) & out_valid & out_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the unused code falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ev_down) state_nxt = EDIT;
            EDIT: begin
                if (ev_down && cursor == '0) state_nxt = COMMIT;
                else if (timed_out)          state_nxt = IDLE;
            end
            COMMIT:  if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        editing   = (state == EDIT);
        dbg_state = state;
    end

    // Entry datapath: value, cursor, snapshot, timeout counter, output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value     <= '0;
            cursor    <= CUR_TOP;
            snapshot  <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            aborted   <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_down) begin
                        cursor   <= CUR_TOP;
                        snapshot <= value;
                        count    <= '0;
                    end
                end
                EDIT: begin
                    if (ev_down) begin
                        count <= '0;
                        if (cursor != '0) begin
                            cursor <= cursor - CUR_W'(1);
                        end else begin
                            out_data  <= value;
                            out_valid <= 1'b1;
                        end
                    end else if (turn_up) begin
                        value <= value_inc;
                        count <= '0;
                    end else if (turn_dn) begin
                        value <= value_dec;
                        count <= '0;
                    end else if (timed_out) begin
                        value   <= snapshot;
                        aborted <= 1'b1;
                        cursor  <= CUR_TOP;
                        count   <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        cursor    <= CUR_TOP;
                    end
                end
                default: begin
                    value     <= '0;
                    cursor    <= CUR_TOP;
                    snapshot  <= '0;
                    count     <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule
